// File: rtl/br_flow_mux_wrr_pkt_stable.sv
// br_flow_mux_wrr_pkt_stable: packet-aware weighted round-robin flow mux with a registered egress stage.
// Optional macro BR_FLOW_MUX_WRR_PKT_COUNT_EN adds a per-flow completed-packet counter output (pkt_count).
module br_flow_mux_wrr_pkt_stable #(
    parameter int NumFlows = 2,
    parameter int Width = 1,
    parameter int WeightWidth = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NumFlows-1:0][WeightWidth-1:0] weight,
    output logic [NumFlows-1:0]                  push_ready,
    input  logic [NumFlows-1:0]                  push_valid,
    input  logic [NumFlows-1:0][Width-1:0]       push_data,
    input  logic [NumFlows-1:0]                  push_last,
    input  logic                                 pop_ready,
    output logic                                 pop_valid,
    output logic [Width-1:0]                     pop_data,
    output logic                                 pop_last
`ifdef BR_FLOW_MUX_WRR_PKT_COUNT_EN
    ,
    output logic [NumFlows-1:0][15:0]            pkt_count
`endif
);
    localparam int IW = $clog2(NumFlows);
    typedef enum logic {ARB, LOCK} state_t;
    state_t state;
    logic [IW-1:0] cur, ptr, sel, idx;
    logic [WeightWidth-1:0] credit, base;
    logic [NumFlows-1:0] elig, grant;
    logic pop_free, cont, fresh, found, xfer, sel_last;

    // Pick the granted flow: hold the packet owner in LOCK, continue its quota at a boundary, else rotate from ptr.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NumFlows; i++) elig[i] = push_valid[i] && (weight[i] != '0);
        cont = (state == ARB) && (credit != '0) && elig[cur];
        fresh = (state == ARB) && !cont;
        found = !fresh;
        sel = cur;
        idx = '0;
        for (int k = 0; k < NumFlows; k++) begin
            idx = IW'((int'(ptr) + k) % NumFlows);
            if (!found && elig[idx]) begin
                found = 1'b1;
                sel = idx;
            end
        end
        grant = found ? (NumFlows'(1) << sel) : '0;
        pop_free = !pop_valid || pop_ready;
        push_ready = grant & {NumFlows{pop_free && !rst}};
        xfer = |(push_valid & push_ready);
        sel_last = push_last[sel];
        base = fresh ? weight[sel] : credit;
    end

    // Output register plus arbitration state; a first beat loads the quota and a last beat consumes one packet of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB;
            cur <= '0;
            ptr <= '0;
            credit <= '0;
            pop_valid <= 1'b0;
            pop_data <= '0;
            pop_last <= 1'b0;
        end else begin
            if (pop_free) pop_valid <= xfer;
            if (xfer) begin
                pop_data <= push_data[sel];
                pop_last <= sel_last;
                cur <= sel;
                if (fresh) ptr <= (sel == IW'(NumFlows - 1)) ? '0 : sel + 1'b1;
                credit <= sel_last ? base - WeightWidth'(base != '0) : base;
                state <= sel_last ? ARB : LOCK;
            end
        end
    end

`ifdef BR_FLOW_MUX_WRR_PKT_COUNT_EN
    // Count packets completed per flow, wrapping at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) pkt_count <= '0;
        else if (xfer && sel_last) pkt_count[sel] <= pkt_count[sel] + 16'd1;
    end
`endif

`ifndef SYNTHESIS
    for (genvar g = 0; g < NumFlows; g++) begin : g_chk
        assert property (@(posedge clk) disable iff (rst)
            push_valid[g] && !push_ready[g] |=> push_valid[g] && $stable(push_data[g]) && $stable(push_last[g]));
        assert property (@(posedge clk) disable iff (rst)
            (state == ARB) && grant[g] |-> weight[g] != '0);
    end
    assert property (@(posedge clk) disable iff (rst)
        pop_valid && !pop_ready |=> pop_valid && $stable(pop_data) && $stable(pop_last));
    assert property (@(posedge clk) $onehot0(grant));
`endif
endmodule

// File: tb/tb_br_flow_mux_wrr_pkt_stable.sv
// tb_br_flow_mux_wrr_pkt_stable: vector table, directed packet sequences and a randomized scoreboard run.
module tb_br_flow_mux_wrr_pkt_stable;
    localparam int NF = 2;
    logic clk = 1'b0;
    logic rst;
    logic [NF-1:0][3:0] weight;
    logic [NF-1:0] push_ready, push_valid, push_last;
    logic [NF-1:0][7:0] push_data;
    logic pop_ready, pop_valid, pop_last;
    logic [7:0] pop_data;
    logic [NF-1:0][15:0] pkt_count;
    int checks = 0;
    int errors = 0;

    br_flow_mux_wrr_pkt_stable #(.NumFlows(NF), .Width(8), .WeightWidth(4)) dut (
        .clk(clk),
        .rst(rst),
        .weight(weight),
        .push_ready(push_ready),
        .push_valid(push_valid),
        .push_data(push_data),
        .push_last(push_last),
        .pop_ready(pop_ready),
        .pop_valid(pop_valid),
        .pop_data(pop_data),
        .pop_last(pop_last)
`ifdef BR_FLOW_MUX_WRR_PKT_COUNT_EN
        ,
        .pkt_count(pkt_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic r;
        logic [3:0] w0, w1;
        logic [1:0] pv;
        logic pr;
        logic [1:0] er;
        logic epv;
        logic [7:0] epd;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic l;
    } beat_t;

    vec_t tbl[$];
    beat_t q[$];
    int m_owner, m_quota, m_next;
    bit m_locked;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic r, input logic [3:0] w0, input logic [3:0] w1, input logic [1:0] pv,
                               input logic pr, input logic [1:0] er, input logic epv, input logic [7:0] epd);
        return '{r, w0, w1, pv, pr, er, epv, epd};
    endfunction

    task automatic cyc(input logic r, input logic [1:0] pv, input logic [1:0] pl, input logic [7:0] d0,
                       input logic [7:0] d1, input logic pr);
        @(negedge clk);
        rst = r;
        push_valid = pv;
        push_last = pl;
        push_data = {d1, d0};
        pop_ready = pr;
        #1;
    endtask

    // Reference arbiter: who should own the egress this cycle, computed from the quota/rotation rules.
    task automatic pick(output int g, output bit fresh);
        g = -1;
        fresh = 1'b0;
        if (m_locked) g = m_owner;
        else if (m_quota > 0 && push_valid[m_owner] && weight[m_owner] != 0) g = m_owner;
        else begin
            fresh = 1'b1;
            for (int k = 0; k < NF; k++) begin
                int j;
                j = (m_next + k) % NF;
                if (g < 0 && push_valid[j] && weight[j] != 0) g = j;
            end
        end
    endtask

    initial begin
        int rem[NF];
        bit acc[NF];
        int g;
        bit fresh;
        logic [NF-1:0] er;
        rst = 1'b1;
        weight = {4'd1, 4'd1};
        push_valid = 2'b11;
        push_last = 2'b11;
        push_data = {8'hB1, 8'hA0};
        pop_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_push_ready", push_ready, 0);
        chk("rst_pop_valid", pop_valid, 0);
        chk("rst_pop_data", pop_data, 0);
        chk("rst_pop_last", pop_last, 0);

        tbl.push_back(v(0, 1, 1, 2'b11, 1, 2'b01, 0, 8'h00));
        tbl.push_back(v(0, 1, 1, 2'b11, 1, 2'b10, 1, 8'hA0));
        tbl.push_back(v(0, 1, 1, 2'b11, 1, 2'b01, 1, 8'hB1));
        tbl.push_back(v(0, 1, 1, 2'b11, 1, 2'b10, 1, 8'hA0));
        tbl.push_back(v(1, 1, 1, 2'b11, 1, 2'b00, 1, 8'hB1));
        tbl.push_back(v(0, 3, 1, 2'b11, 1, 2'b01, 0, 8'h00));
        tbl.push_back(v(0, 3, 1, 2'b11, 1, 2'b01, 1, 8'hA0));
        tbl.push_back(v(0, 3, 1, 2'b11, 1, 2'b01, 1, 8'hA0));
        tbl.push_back(v(0, 3, 1, 2'b11, 1, 2'b10, 1, 8'hA0));
        tbl.push_back(v(0, 3, 1, 2'b11, 1, 2'b01, 1, 8'hB1));
        tbl.push_back(v(0, 3, 1, 2'b11, 1, 2'b01, 1, 8'hA0));
        tbl.push_back(v(0, 3, 1, 2'b11, 0, 2'b00, 1, 8'hA0));
        tbl.push_back(v(0, 3, 1, 2'b11, 1, 2'b01, 1, 8'hA0));
        tbl.push_back(v(0, 3, 1, 2'b11, 1, 2'b10, 1, 8'hA0));
        tbl.push_back(v(1, 0, 2, 2'b11, 1, 2'b00, 1, 8'hB1));
        tbl.push_back(v(0, 0, 2, 2'b11, 1, 2'b10, 0, 8'h00));
        tbl.push_back(v(0, 0, 2, 2'b11, 1, 2'b10, 1, 8'hB1));
        tbl.push_back(v(0, 0, 2, 2'b11, 1, 2'b10, 1, 8'hB1));
        tbl.push_back(v(0, 0, 2, 2'b11, 1, 2'b10, 1, 8'hB1));
        for (int i = 0; i < tbl.size(); i++) begin
            weight = {tbl[i].w1, tbl[i].w0};
            cyc(tbl[i].r, tbl[i].pv, 2'b11, 8'hA0, 8'hB1, tbl[i].pr);
            chk($sformatf("tbl%0d_push_ready", i), push_ready, tbl[i].er);
            chk($sformatf("tbl%0d_pop_valid", i), pop_valid, tbl[i].epv);
            if (tbl[i].epv) chk($sformatf("tbl%0d_pop_data", i), pop_data, tbl[i].epd);
        end

        weight = {4'd1, 4'd1};
        cyc(1, 2'b00, 2'b00, 8'h00, 8'h00, 1);
        cyc(0, 2'b01, 2'b00, 8'h01, 8'h00, 1);
        chk("lock_b1_ready", push_ready, 2'b01);
        cyc(0, 2'b11, 2'b10, 8'h02, 8'h55, 1);
        chk("lock_b2_ready", push_ready, 2'b01);
        chk("lock_b1_data", pop_data, 8'h01);
        cyc(0, 2'b11, 2'b10, 8'h03, 8'h55, 1);
        chk("lock_b3_ready", push_ready, 2'b01);
        chk("lock_b2_data", pop_data, 8'h02);
        cyc(0, 2'b11, 2'b11, 8'h04, 8'h55, 1);
        chk("lock_b4_ready", push_ready, 2'b01);
        chk("lock_b3_data", pop_data, 8'h03);
        cyc(0, 2'b10, 2'b10, 8'h00, 8'h55, 1);
        chk("lock_f1_ready", push_ready, 2'b10);
        chk("lock_b4_data", pop_data, 8'h04);
        chk("lock_b4_last", pop_last, 1);
        cyc(0, 2'b00, 2'b00, 8'h00, 8'h00, 1);
        chk("lock_f1_data", pop_data, 8'h55);
        chk("lock_f1_valid", pop_valid, 1);

        cyc(1, 2'b00, 2'b00, 8'h00, 8'h00, 1);
        cyc(0, 2'b11, 2'b10, 8'h10, 8'h20, 1);
        chk("stall_start_ready", push_ready, 2'b01);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 2'b11, 2'b10, 8'h11, 8'h20, 0);
            chk("stall_ready", push_ready, 2'b00);
            chk("stall_valid", pop_valid, 1);
            chk("stall_data", pop_data, 8'h10);
            chk("stall_last", pop_last, 0);
        end
        cyc(0, 2'b11, 2'b10, 8'h11, 8'h20, 1);
        chk("stall_release_ready", push_ready, 2'b01);
        chk("stall_release_data", pop_data, 8'h10);
        cyc(0, 2'b11, 2'b11, 8'h12, 8'h20, 1);
        chk("stall_b3_ready", push_ready, 2'b01);
        chk("stall_b2_data", pop_data, 8'h11);
        cyc(0, 2'b10, 2'b10, 8'h00, 8'h20, 1);
        chk("stall_f1_ready", push_ready, 2'b10);
        chk("stall_b3_data", pop_data, 8'h12);
        cyc(0, 2'b00, 2'b00, 8'h00, 8'h00, 1);
        chk("stall_f1_data", pop_data, 8'h20);
        cyc(0, 2'b00, 2'b00, 8'h00, 8'h00, 1);
        chk("stall_no_dup", pop_valid, 0);

        cyc(1, 2'b00, 2'b00, 8'h00, 8'h00, 1);
        cyc(0, 2'b01, 2'b00, 8'h30, 8'h00, 1);
        chk("mrst_b1_ready", push_ready, 2'b01);
        cyc(1, 2'b01, 2'b00, 8'h31, 8'h00, 1);
        chk("mrst_ready_in_rst", push_ready, 2'b00);
        cyc(0, 2'b11, 2'b11, 8'h40, 8'h50, 1);
        chk("mrst_pop_valid", pop_valid, 0);
        chk("mrst_f0_first", push_ready, 2'b01);
        cyc(0, 2'b10, 2'b11, 8'h00, 8'h50, 1);
        chk("mrst_arb_f1", push_ready, 2'b10);
        chk("mrst_f0_data", pop_data, 8'h40);
        cyc(0, 2'b00, 2'b00, 8'h00, 8'h00, 1);
        chk("mrst_f1_data", pop_data, 8'h50);

        weight = {4'($urandom_range(1, 3)), 4'($urandom_range(1, 3))};
        cyc(1, 2'b00, 2'b00, 8'h00, 8'h00, 1);
        m_owner = 0;
        m_quota = 0;
        m_next = 0;
        m_locked = 1'b0;
        q.delete();
        for (int i = 0; i < NF; i++) begin
            rem[i] = 0;
            acc[i] = 1'b0;
        end
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            chk("rnd_pop_valid", pop_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("rnd_pop_data", pop_data, q[0].d);
                chk("rnd_pop_last", pop_last, q[0].l);
            end
            rst = 1'b0;
            if ($urandom_range(0, 31) == 0) weight[$urandom_range(0, NF - 1)] = 4'($urandom_range(0, 3));
            for (int i = 0; i < NF; i++) begin
                if (!(push_valid[i] && !acc[i])) begin
                    if (rem[i] == 0 && $urandom_range(0, 4) < 3) rem[i] = $urandom_range(1, 4);
                    push_valid[i] = rem[i] > 0 && $urandom_range(0, 3) != 0;
                    push_data[i] = 8'($urandom);
                    push_last[i] = rem[i] == 1;
                end
            end
            pop_ready = $urandom_range(0, 3) != 0;
            #1;
            g = -1;
            fresh = 1'b0;
            if (q.size() == 0 || pop_ready) pick(g, fresh);
            er = (g >= 0) ? NF'(1) << g : '0;
            chk("rnd_push_ready", push_ready, er);
            for (int i = 0; i < NF; i++) begin
                acc[i] = push_valid[i] && push_ready[i];
                if (acc[i]) rem[i]--;
            end
            if (q.size() != 0 && pop_ready) void'(q.pop_front());
            if (g >= 0 && push_valid[g]) begin
                q.push_back('{push_data[g], push_last[g]});
                if (fresh) begin
                    m_owner = g;
                    m_quota = int'(weight[g]);
                    m_next = (g + 1) % NF;
                end
                if (push_last[g]) begin
                    m_locked = 1'b0;
                    if (m_quota > 0) m_quota--;
                end else m_locked = 1'b1;
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
